pipe_skid_reg: RTL and testbench

- Generic, parametrised pipeline stage register for the RISC-V core.
- Replaces the fixed, always-advancing inter-stage registers with a valid/ready handshake.
- Uses a 2-entry skid buffer, so o_ready is a pure register output and the upstream ready path is timing-isolated.
- Supports per-stage flush for branch/exception squash and stall via downstream backpressure.

---
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush and backpressure.
// Optional performance counters are enabled by defining PIPE_SKID_REG_PERF_EN.
module pipe_skid_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef PIPE_SKID_REG_PERF_EN
    ,
    output logic [15:0]           o_stall_cnt,
    output logic [15:0]           o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  up_xfer;
    logic                  dn_xfer;

    assign up_xfer = i_valid && o_ready;
    assign dn_xfer = o_valid && i_ready;
    assign o_data  = main_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (up_xfer) state_nxt = FULL;
                FULL: begin
                    if (dn_xfer && !up_xfer)      state_nxt = EMPTY;
                    else if (up_xfer && !dn_xfer) state_nxt = SKID;
                end
                SKID:    if (dn_xfer) state_nxt = FULL;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs decode from the registered state only, keeping o_ready off the i_ready path.
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        case (state)
            EMPTY: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
            FULL: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
            end
            SKID: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
        endcase
    end

    // NOTE: both payload entries are reset because RESET_VAL is architecturally visible on o_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (i_flush) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            case (state)
                EMPTY: if (up_xfer) main_q <= i_data;
                FULL: begin
                    if (up_xfer && dn_xfer) main_q <= i_data;
                    else if (up_xfer)       skid_q <= i_data;
                end
                SKID:    if (dn_xfer) main_q <= skid_q;
                default: ;
            endcase
        end
    end

`ifdef PIPE_SKID_REG_PERF_EN
    // Saturating counters; flush leaves them alone so they span squashes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stall_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (o_valid && !i_ready && (o_stall_cnt != 16'hFFFF)) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
            if (!o_valid && (o_bubble_cnt != 16'hFFFF)) begin
                o_bubble_cnt <= o_bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed cases then random traffic against a queue model.
// Counter checks are compiled in when PIPE_SKID_REG_PERF_EN is defined.
module tb_pipe_skid_reg;

    localparam int          DW        = 32;
    localparam logic [31:0] RESET_VAL = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
`ifdef PIPE_SKID_REG_PERF_EN
    logic [15:0]   o_stall_cnt;
    logic [15:0]   o_bubble_cnt;
`endif

    pipe_skid_reg #(.DATA_WIDTH(DW), .RESET_VAL(RESET_VAL)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data)
`ifdef PIPE_SKID_REG_PERF_EN
        ,
        .o_stall_cnt  (o_stall_cnt),
        .o_bubble_cnt (o_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the stage is a 2-deep FIFO; ready whenever fewer than two beats are held.
    logic [31:0] m_q[$];
    logic [31:0] delivered[$];
    bit          m_reset_data;
    int          m_stall;
    int          m_bubble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(o_valid), 32'(m_q.size() > 0));
        check({tag, ".ready"}, 32'(o_ready), 32'(m_q.size() < 2));
        if (m_q.size() > 0)    check({tag, ".data"}, o_data, m_q[0]);
        else if (m_reset_data) check({tag, ".data"}, o_data, RESET_VAL);
`ifdef PIPE_SKID_REG_PERF_EN
        check({tag, ".stall"}, 32'(o_stall_cnt), 32'(m_stall));
        check({tag, ".bubble"}, 32'(o_bubble_cnt), 32'(m_bubble));
`endif
    endtask

    // One clock: check outputs at the negedge, drive inputs, advance the model over the posedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f,
                         input string tag);
        bit up;
        bit dn;
        check_model(tag);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        up = v && (m_q.size() < 2);
        dn = (m_q.size() > 0) && r;
        @(posedge clk);
        if (m_q.size() == 0 && m_bubble < 65535) m_bubble++;
        if (m_q.size() > 0 && !r && m_stall < 65535) m_stall++;
        if (dn) delivered.push_back(m_q[0]);
        if (f) begin
            m_q.delete();
            m_reset_data = 1'b1;
        end else begin
            if (dn) void'(m_q.pop_front());
            if (up) begin
                m_q.push_back(d);
                m_reset_data = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        delivered.delete();
        m_reset_data = 1'b1;
        m_stall      = 0;
        m_bubble     = 0;
    endtask

    initial begin
        // Reset state
        reset_dut();
        check("reset.valid", 32'(o_valid), 32'd0);
        check("reset.ready", 32'(o_ready), 32'd1);
        check("reset.data", o_data, RESET_VAL);

`ifdef PIPE_SKID_REG_PERF_EN
        // Counters: 3 idle cycles, fill with 0x55, then 5 stalled cycles
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0, "perf_idle");
        cycle(1'b1, 32'h55, 1'b0, 1'b0, "perf_fill");
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0, "perf_hold");
        check("perf.stall_cnt", 32'(o_stall_cnt), 32'd5);
        check("perf.bubble_cnt", 32'(o_bubble_cnt), 32'd4);
        check("perf.data", o_data, 32'h55);
        reset_dut();
`endif

        // Streaming 1..8 with i_ready high: one beat per cycle, no gaps
        for (int k = 1; k <= 8; k++) cycle(1'b1, 32'(k), 1'b1, 1'b0, "stream");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "stream_tail");
        check("stream.count", 32'(delivered.size()), 32'd8);
        for (int k = 0; k < 8; k++) check("stream.order", delivered[k], 32'(k + 1));

        // Backpressure: 0xA held, 0xB lands in skid, ready drops, then drains in order
        reset_dut();
        cycle(1'b1, 32'hA, 1'b1, 1'b0, "bp_a");
        cycle(1'b1, 32'hB, 1'b0, 1'b0, "bp_b");
        check("bp.ready_low", 32'(o_ready), 32'd0);
        check("bp.head", o_data, 32'hA);
        cycle(1'b1, 32'hEE, 1'b0, 1'b0, "bp_hold");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain_a");
        check("bp.second", o_data, 32'hB);
        check("bp.ready_back", 32'(o_ready), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain_b");
        check("bp.count", 32'(delivered.size()), 32'd2);
        check("bp.first_out", delivered[0], 32'hA);
        check("bp.second_out", delivered[1], 32'hB);

        // Flush in SKID with a concurrent upstream beat: everything is dropped
        reset_dut();
        cycle(1'b1, 32'h11, 1'b0, 1'b0, "fl_11");
        cycle(1'b1, 32'h22, 1'b0, 1'b0, "fl_22");
        cycle(1'b1, 32'h33, 1'b0, 1'b1, "fl_skid");
        check("flush.valid", 32'(o_valid), 32'd0);
        check("flush.ready", 32'(o_ready), 32'd1);
        check("flush.data", o_data, RESET_VAL);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, "fl_after");
        check("flush.none_out", 32'(delivered.size()), 32'd0);

        // Flush in FULL with a downstream transfer on the same edge: 0x44 still delivered
        reset_dut();
        cycle(1'b1, 32'h44, 1'b1, 1'b0, "fd_44");
        cycle(1'b0, 32'h0, 1'b1, 1'b1, "fd_flush");
        check("flush_dn.count", 32'(delivered.size()), 32'd1);
        check("flush_dn.beat", delivered[0], 32'h44);
        check("flush_dn.empty", 32'(o_valid), 32'd0);

        // Asynchronous reset while in SKID, sampled between clock edges
        cycle(1'b1, 32'hC1, 1'b0, 1'b0, "ar_c1");
        cycle(1'b1, 32'hC2, 1'b0, 1'b0, "ar_c2");
        check("areset.pre_ready", 32'(o_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("areset.valid", 32'(o_valid), 32'd0);
        check("areset.ready", 32'(o_ready), 32'd1);
        check("areset.data", o_data, RESET_VAL);
        reset_dut();

        // Random traffic with occasional flushes against the queue model
        for (int n = 0; n < 600; n++) begin
            cycle(1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 3) != 0),
                  1'(($urandom % 24) == 0), "rand");
        end
        check_model("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
